mem_arbiter: RTL and testbench

Arbitrates one shared single-port memory between the instruction-fetch (I) and data-access (D) ports of the 5-stage pipeline. Sequences each access with a request/ack handshake to the memory. Drives per-port stall signals that freeze the PC, IF_ID and downstream pipeline registers. D has priority, with a bounded anti-starvation rule for I and a timeout for a non-responding memory.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared encodings and default widths for the memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int unsigned c_ADDR_W      = 32;
    localparam int unsigned c_DATA_W      = 32;
    localparam int unsigned c_MAX_D_BURST = 4;
    localparam int unsigned c_TIMEOUT     = 16;

    typedef logic [1:0] state_t;
    typedef logic       owner_t;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic c_OWN_D = 1'b0;
    localparam logic c_OWN_I = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : fetch/data request ports and memory bus of the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_stall_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              err_o;

    // The arbiter masters the memory bus and serves the pipeline ports.
    modport master (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output i_rdata_o, i_stall_o, d_rdata_o, d_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport slave (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  i_rdata_o, i_stall_o, d_rdata_o, d_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// ============================================================================
// mem_arb_pick : combinational grant selection between fetch and data ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int MAX_D_BURST = 4
) (
    input  wire logic             i_i_req,
    input  wire logic             i_d_req,
    input  wire logic [CNT_W-1:0] i_burst_cnt,
    output logic                  o_grant,
    output logic                  o_owner
);

    logic w_force_i;

    assign w_force_i = (i_burst_cnt == CNT_W'(MAX_D_BURST));
    assign o_grant   = i_i_req | i_d_req;

    // D wins unless it has used up its burst allowance while I waits.
    assign o_owner   = (i_d_req && !(i_i_req && w_force_i)) ? c_OWN_D : c_OWN_I;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one single-port memory between fetch and data ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int MAX_D_BURST = c_MAX_D_BURST,
    parameter int TIMEOUT     = c_TIMEOUT
) (
    input  wire logic      clk_i,
    input  wire logic      rst_n,
    mem_arbiter_if.master  bus
);

    localparam int c_BCNT_W = $clog2(MAX_D_BURST + 1);
    localparam int c_TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]          r_state;
    logic                r_owner;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic w_grant;
    logic w_pick_owner;
    logic w_busy;
    logic w_resp;
    logic w_own_d;
    logic w_timeout;

    mem_arb_pick #(
        .CNT_W       (c_BCNT_W),
        .MAX_D_BURST (MAX_D_BURST)
    ) u_pick (
        .i_i_req     (bus.i_req_i),
        .i_d_req     (bus.d_req_i),
        .i_burst_cnt (r_bcnt),
        .o_grant     (w_grant),
        .o_owner     (w_pick_owner)
    );

    assign w_busy    = (r_state == c_ST_BUSY);
    assign w_resp    = (r_state == c_ST_RESP);
    assign w_own_d   = (r_owner == c_OWN_D);
    assign w_timeout = w_busy && !bus.mem_ack_i && (r_tcnt == c_TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_owner <= c_OWN_D;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_err  <= 1'b0;
                    r_tcnt <= '0;
                    if (w_grant) begin
                        r_state <= c_ST_BUSY;
                        r_owner <= w_pick_owner;
                        // Burst counter only grows while I is actually waiting.
                        if (w_pick_owner == c_OWN_I || !bus.i_req_i) begin
                            r_bcnt <= '0;
                        end else if (r_bcnt != c_BCNT_W'(MAX_D_BURST)) begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (bus.mem_ack_i) begin
                        r_state <= c_ST_RESP;
                        r_rdata <= (w_own_d && bus.d_we_i) ? '0 : bus.mem_rdata_i;
                    end else if (w_timeout) begin
                        r_state <= c_ST_RESP;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_tcnt  <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tcnt  <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = w_busy;
    assign bus.mem_addr_o  = w_busy ? (w_own_d ? bus.d_addr_i : bus.i_addr_i) : '0;
    assign bus.mem_we_o    = w_busy && w_own_d && bus.d_we_i;
    assign bus.mem_wdata_o = (w_busy && w_own_d) ? bus.d_wdata_i : '0;

    assign bus.d_stall_o   = bus.d_req_i & ~(w_resp & w_own_d);
    assign bus.i_stall_o   = bus.i_req_i & ~(w_resp & ~w_own_d);

    assign bus.d_rdata_o   = w_own_d ? r_rdata : '0;
    assign bus.i_rdata_o   = w_own_d ? '0 : r_rdata;
    assign bus.err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic clk_i = 1'b0;
    logic rst_n;

    always #5 clk_i = ~clk_i;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (4),
        .TIMEOUT     (16)
    ) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          mem_lat    = 0;
    bit          mem_noack  = 1'b0;
    logic [31:0] resp_data  = '0;
    int          busy_cnt   = 0;

    logic [31:0] grant_log [16];
    int          grant_cnt  = 0;
    logic        prev_req   = 1'b0;

    // Memory model: acks after mem_lat wait cycles unless told to stay silent.
    always @(negedge clk_i) begin
        if (bus.mem_req_o && !mem_noack) begin
            if (busy_cnt == mem_lat) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = resp_data;
                busy_cnt        = 0;
            end else begin
                bus.mem_ack_i   = 1'b0;
                busy_cnt        = busy_cnt + 1;
            end
        end else begin
            bus.mem_ack_i = 1'b0;
            busy_cnt      = 0;
        end
    end

    always @(negedge clk_i) begin
        if (bus.mem_req_o && !prev_req && grant_cnt < 16) begin
            grant_log[grant_cnt] = bus.mem_addr_o;
            grant_cnt            = grant_cnt + 1;
        end
        prev_req = bus.mem_req_o;
    end

    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bus.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req_o);
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %0b want 0", bus.err_o);
        end
        checks++;
        if (bus.d_rdata_o !== 32'h0 || bus.i_rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got d=%h i=%h want 0", bus.d_rdata_o, bus.i_rdata_o);
        end
        checks++;
        if (bus.d_stall_o !== 1'b0 || bus.i_stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall_idle: got d=%0b i=%0b want 0", bus.d_stall_o, bus.i_stall_o);
        end
        bus.d_req_i = 1'b1;
        #1;
        checks++;
        if (bus.d_stall_o !== 1'b1) begin
            errors++; $display("FAIL reset_stall_comb: got %0b want 1", bus.d_stall_o);
        end
        bus.d_req_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_load;
        mem_lat = 0; resp_data = 32'hDEADBEEF;
        bus.d_we_i = 1'b0; bus.d_addr_i = 32'h40; bus.d_req_i = 1'b1;
        #1;
        checks++;
        if (bus.d_stall_o !== 1'b1) begin
            errors++; $display("FAIL load_stall_c1: got %0b want 1", bus.d_stall_o);
        end
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40 || bus.mem_we_o !== 1'b0) begin
            errors++; $display("FAIL load_busy: got req=%0b addr=%h we=%0b want 1/40/0",
                               bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o);
        end
        tick();
        checks++;
        if (bus.d_stall_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL load_resp_c3: got stall=%0b req=%0b want 0/0", bus.d_stall_o, bus.mem_req_o);
        end
        checks++;
        if (bus.d_rdata_o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_rdata: got %h want deadbeef", bus.d_rdata_o);
        end
        bus.d_req_i = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        mem_lat = 1; resp_data = 32'hAAAA0001;
        bus.d_addr_i = 32'h80; bus.i_addr_i = 32'h200;
        bus.d_req_i = 1'b1; bus.i_req_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_addr_o !== 32'h80 || bus.i_stall_o !== 1'b1) begin
            errors++; $display("FAIL cont_d_first: got addr=%h istall=%0b want 80/1", bus.mem_addr_o, bus.i_stall_o);
        end
        tick();
        checks++;
        if (bus.i_stall_o !== 1'b1 || bus.d_stall_o !== 1'b1 || bus.mem_req_o !== 1'b1) begin
            errors++; $display("FAIL cont_busy2: got istall=%0b dstall=%0b req=%0b want 1/1/1",
                               bus.i_stall_o, bus.d_stall_o, bus.mem_req_o);
        end
        tick();
        checks++;
        if (bus.d_stall_o !== 1'b0 || bus.i_stall_o !== 1'b1 || bus.d_rdata_o !== 32'hAAAA0001) begin
            errors++; $display("FAIL cont_d_resp: got dstall=%0b istall=%0b rdata=%h want 0/1/aaaa0001",
                               bus.d_stall_o, bus.i_stall_o, bus.d_rdata_o);
        end
        bus.d_req_i = 1'b0; resp_data = 32'hBBBB0002;
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.i_stall_o !== 1'b1) begin
            errors++; $display("FAIL cont_idle_gap: got req=%0b istall=%0b want 0/1", bus.mem_req_o, bus.i_stall_o);
        end
        tick();
        checks++;
        if (bus.mem_addr_o !== 32'h200 || bus.mem_we_o !== 1'b0 || bus.mem_req_o !== 1'b1) begin
            errors++; $display("FAIL cont_i_busy: got addr=%h we=%0b req=%0b want 200/0/1",
                               bus.mem_addr_o, bus.mem_we_o, bus.mem_req_o);
        end
        tick();
        tick();
        checks++;
        if (bus.i_stall_o !== 1'b0 || bus.i_rdata_o !== 32'hBBBB0002 || bus.d_rdata_o !== 32'h0) begin
            errors++; $display("FAIL cont_i_resp: got istall=%0b irdata=%h drdata=%h want 0/bbbb0002/0",
                               bus.i_stall_o, bus.i_rdata_o, bus.d_rdata_o);
        end
        bus.i_req_i = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        logic [31:0] exp_log [6];
        bit moved;
        exp_log = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h300, 32'h100};
        moved = 1'b0;
        mem_lat = 0; resp_data = 32'hCAFE0000;
        grant_cnt = 0;
        bus.d_we_i = 1'b0; bus.d_addr_i = 32'h100; bus.i_addr_i = 32'h300;
        bus.d_req_i = 1'b1; bus.i_req_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!moved && bus.i_stall_o == 1'b0) begin
                moved = 1'b1;
                bus.i_addr_i = 32'h304;
            end
            if (grant_cnt >= 6) break;
        end
        bus.d_req_i = 1'b0; bus.i_req_i = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (grant_cnt !== 6) begin
            errors++; $display("FAIL starve_grant_count: got %0d want 6", grant_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (grant_log[k] !== exp_log[k]) begin
                errors++; $display("FAIL starve_grant_%0d: got addr %h want %h", k, grant_log[k], exp_log[k]);
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        mem_noack = 1'b1;
        bus.d_we_i = 1'b0; bus.d_addr_i = 32'h44; bus.d_req_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.mem_req_o) n++;
            else break;
        end
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL timeout_busy_cycles: got %0d want 16", n);
        end
        checks++;
        if (bus.err_o !== 1'b1 || bus.d_rdata_o !== 32'h0 || bus.d_stall_o !== 1'b0) begin
            errors++; $display("FAIL timeout_resp: got err=%0b rdata=%h stall=%0b want 1/0/0",
                               bus.err_o, bus.d_rdata_o, bus.d_stall_o);
        end
        bus.d_req_i = 1'b0;
        tick();
        checks++;
        if (bus.err_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: got err=%0b req=%0b want 0/0", bus.err_o, bus.mem_req_o);
        end
        mem_noack = 1'b0;
    endtask

    task automatic test_store;
        mem_lat = 0; resp_data = 32'h55555555;
        bus.d_we_i = 1'b1; bus.d_wdata_i = 32'h12345678; bus.d_addr_i = 32'h48; bus.d_req_i = 1'b1;
        #1;
        checks++;
        if (bus.mem_we_o !== 1'b0 || bus.mem_wdata_o !== 32'h0) begin
            errors++; $display("FAIL store_idle: got we=%0b wdata=%h want 0/0", bus.mem_we_o, bus.mem_wdata_o);
        end
        tick();
        checks++;
        if (bus.mem_we_o !== 1'b1 || bus.mem_wdata_o !== 32'h12345678 || bus.mem_addr_o !== 32'h48) begin
            errors++; $display("FAIL store_busy: got we=%0b wdata=%h addr=%h want 1/12345678/48",
                               bus.mem_we_o, bus.mem_wdata_o, bus.mem_addr_o);
        end
        tick();
        checks++;
        if (bus.mem_we_o !== 1'b0 || bus.mem_wdata_o !== 32'h0 || bus.d_stall_o !== 1'b0
            || bus.d_rdata_o !== 32'h0) begin
            errors++; $display("FAIL store_resp: got we=%0b wdata=%h stall=%0b rdata=%h want 0/0/0/0",
                               bus.mem_we_o, bus.mem_wdata_o, bus.d_stall_o, bus.d_rdata_o);
        end
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
        tick();
        checks++;
        if (bus.mem_we_o !== 1'b0) begin
            errors++; $display("FAIL store_after: got we=%0b want 0", bus.mem_we_o);
        end
    endtask

    task automatic test_reset_mid_busy;
        mem_noack = 1'b1;
        bus.d_we_i = 1'b0; bus.d_addr_i = 32'h4C; bus.d_req_i = 1'b1;
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy: got %0b want 1", bus.mem_req_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req_o !== 1'b0 || bus.d_stall_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_async: got req=%0b stall=%0b want 0/1", bus.mem_req_o, bus.d_stall_o);
        end
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_held: got %0b want 0", bus.mem_req_o);
        end
        rst_n = 1'b1; mem_noack = 1'b0; mem_lat = 0; resp_data = 32'h0BADF00D;
        tick();
        checks++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h4C) begin
            errors++; $display("FAIL rstmid_rearb: got req=%0b addr=%h want 1/4c", bus.mem_req_o, bus.mem_addr_o);
        end
        tick();
        checks++;
        if (bus.d_stall_o !== 1'b0 || bus.d_rdata_o !== 32'h0BADF00D) begin
            errors++; $display("FAIL rstmid_resp: got stall=%0b rdata=%h want 0/0badf00d", bus.d_stall_o, bus.d_rdata_o);
        end
        bus.d_req_i = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_req_i     = 1'b0;
        bus.i_addr_i    = '0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;

        test_reset();
        test_single_load();
        test_contention();
        test_starvation();
        test_timeout();
        test_store();
        test_reset_mid_busy();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
